// File: rtl/soc_run_ctrl_pkg.sv
// Shared types and helpers for the SoC run controller: FSM states,
// end-status codes and the saturating cycle-counter increment.
package soc_run_ctrl_pkg;

    localparam int CYCLE_CNT_W = 32;

    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } run_state_e;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_TRAP    = 2'b01,
        ST_TIMEOUT = 2'b10
    } run_status_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CYCLE_CNT_W-1:0] sat_inc(input logic [CYCLE_CNT_W-1:0] v);
        logic [CYCLE_CNT_W-1:0] r;
        if (v == {CYCLE_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CYCLE_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/soc_run_ctrl.sv
// Run controller: holds core reset after board reset, runs until a trap (or
// the watchdog when SOC_RUN_CTRL_TIMEOUT_EN is defined), drains, then halts.
module soc_run_ctrl
    import soc_run_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 10,
    parameter int DRAIN_CYCLES    = 10,
    parameter int NUM_HARTS       = 1,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_HARTS-1:0]   i_trap,
    input  logic                   i_restart,
    output logic                   o_core_rst_n,
    output logic                   o_done,
    output logic [1:0]             o_status,
    output logic [NUM_HARTS-1:0]   o_trap_mask,
    output logic [CYCLE_CNT_W-1:0] o_cycle_count
);

    localparam int CNT_MAX = max3(RST_HOLD_CYCLES, DRAIN_CYCLES, 1);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam bit DRAIN_NONE = (DRAIN_CYCLES == 0);

    run_state_e             state_r;
    run_status_e            status_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   core_rst_n_r;
    logic                   done_r;
    logic [NUM_HARTS-1:0]   trap_mask_r;
    logic [CYCLE_CNT_W-1:0] cycle_cnt_r;

    logic                   trap_any_s;
    logic                   timeout_hit_s;
    logic                   cnt_zero_s;
    logic [CYCLE_CNT_W-1:0] cycle_next_s;

    // Per-cycle decode of trap lines, shared counter and next cycle count.
    always_comb begin
        trap_any_s   = |i_trap;
        cnt_zero_s   = (cnt_r == {CNT_W{1'b0}});
        cycle_next_s = sat_inc(cycle_cnt_r);
    end

`ifdef SOC_RUN_CTRL_TIMEOUT_EN
    localparam logic [CYCLE_CNT_W-1:0] TIMEOUT_LAST = CYCLE_CNT_W'(TIMEOUT_CYCLES - 1);

    // Watchdog compares the registered count, so it fires on the TIMEOUT-th RUN edge.
    always_comb begin
        if (cycle_cnt_r == TIMEOUT_LAST) begin
            timeout_hit_s = 1'b1;
        end else begin
            timeout_hit_s = 1'b0;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Run sequencer with all outputs registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= HOLD;
            cnt_r        <= HOLD_LOAD;
            core_rst_n_r <= 1'b0;
            done_r       <= 1'b0;
            status_r     <= ST_NONE;
            trap_mask_r  <= {NUM_HARTS{1'b0}};
            cycle_cnt_r  <= {CYCLE_CNT_W{1'b0}};
        end else begin
            case (state_r)
                HOLD: begin
                    if (cnt_zero_s) begin
                        state_r      <= RUN;
                        core_rst_n_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                RUN: begin
                    cycle_cnt_r <= cycle_next_s;
                    if (trap_any_s || timeout_hit_s) begin
                        // A trap on the same edge as the timeout takes priority.
                        if (trap_any_s) begin
                            status_r    <= ST_TRAP;
                            trap_mask_r <= i_trap;
                        end else begin
                            status_r    <= ST_TIMEOUT;
                            trap_mask_r <= {NUM_HARTS{1'b0}};
                        end
                        if (DRAIN_NONE) begin
                            state_r      <= DONE;
                            core_rst_n_r <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                            cnt_r   <= DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    cycle_cnt_r <= cycle_next_s;
                    if (cnt_zero_s) begin
                        state_r      <= DONE;
                        core_rst_n_r <= 1'b0;
                        done_r       <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (i_restart) begin
                        state_r     <= HOLD;
                        cnt_r       <= HOLD_LOAD;
                        done_r      <= 1'b0;
                        status_r    <= ST_NONE;
                        trap_mask_r <= {NUM_HARTS{1'b0}};
                        cycle_cnt_r <= {CYCLE_CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_r      <= HOLD;
                    cnt_r        <= HOLD_LOAD;
                    core_rst_n_r <= 1'b0;
                    done_r       <= 1'b0;
                    status_r     <= ST_NONE;
                    trap_mask_r  <= {NUM_HARTS{1'b0}};
                    cycle_cnt_r  <= {CYCLE_CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign o_core_rst_n  = core_rst_n_r;
    assign o_done        = done_r;
    assign o_status      = status_r;
    assign o_trap_mask   = trap_mask_r;
    assign o_cycle_count = cycle_cnt_r;

endmodule

// File: tb/tb_soc_run_ctrl.sv
// Bench for soc_run_ctrl: two instances (long drain / zero drain) checked every
// cycle against a timeline model, plus hand-computed pins of key edges.
module tb_soc_run_ctrl;

`ifdef SOC_RUN_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        tb_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  trap_a, trap_b;
    logic        restart_a, restart_b;
    logic        core_rst_n_a, core_rst_n_b;
    logic        done_a, done_b;
    logic [1:0]  status_a, status_b;
    logic [3:0]  mask_a, mask_b;
    logic [31:0] count_a, count_b;

    always #5 tb_clk = ~tb_clk;

    soc_run_ctrl #(.RST_HOLD_CYCLES(10), .DRAIN_CYCLES(10), .NUM_HARTS(4), .TIMEOUT_CYCLES(1000)) dut_a (
        .i_clk(tb_clk), .i_rst_n(rst_n), .i_trap(trap_a), .i_restart(restart_a),
        .o_core_rst_n(core_rst_n_a), .o_done(done_a), .o_status(status_a),
        .o_trap_mask(mask_a), .o_cycle_count(count_a));

    soc_run_ctrl #(.RST_HOLD_CYCLES(3), .DRAIN_CYCLES(0), .NUM_HARTS(4), .TIMEOUT_CYCLES(100)) dut_b (
        .i_clk(tb_clk), .i_rst_n(rst_n), .i_trap(trap_b), .i_restart(restart_b),
        .o_core_rst_n(core_rst_n_b), .o_done(done_b), .o_status(status_b),
        .o_trap_mask(mask_b), .o_cycle_count(count_b));

    // Timeline model: remembers the edge the core leaves reset and the end-event edge.
    typedef struct packed {
        int         hold;
        int         drain;
        int         tmo;
        bit         in_reset;
        int         rise;
        bit         ended;
        int         done_e;
        logic [1:0] st;
        logic [3:0] mask;
    } mdl_t;

    typedef struct packed {
        logic        core;
        logic        done;
        logic [1:0]  st;
        logic [3:0]  mask;
        logic [31:0] cnt;
    } exp_t;

    mdl_t mdl [2];
    int   edge_n;
    int   n_checks;
    int   n_errors;
    bit   chk_en;

    function automatic mdl_t mdl_init(input int hold, input int drain, input int tmo);
        mdl_t r;
        r = '0;
        r.hold = hold;
        r.drain = drain;
        r.tmo = tmo;
        r.in_reset = 1'b1;
        return r;
    endfunction

    function automatic mdl_t mdl_rst(input mdl_t m);
        mdl_t r;
        r = m;
        r.in_reset = 1'b1;
        r.ended = 1'b0;
        r.st = 2'b00;
        r.mask = 4'b0000;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int n, input logic [3:0] trap, input logic restart);
        mdl_t r;
        r = m;
        if (r.in_reset) begin
            r.in_reset = 1'b0;
            r.rise = n + r.hold - 1;
        end else if (r.ended) begin
            if (n > r.done_e && restart) begin
                r.ended = 1'b0;
                r.rise = n + r.hold;
                r.st = 2'b00;
                r.mask = 4'b0000;
            end
        end else if (n > r.rise) begin
            if (trap != 4'b0000) begin
                r.ended = 1'b1;
                r.done_e = n + r.drain;
                r.st = 2'b01;
                r.mask = trap;
            end else if (TMO_EN && (n - 1 - r.rise) == r.tmo - 1) begin
                r.ended = 1'b1;
                r.done_e = n + r.drain;
                r.st = 2'b10;
                r.mask = 4'b0000;
            end
        end
        return r;
    endfunction

    function automatic exp_t mdl_exp(input mdl_t m, input int n);
        exp_t e;
        e = '0;
        if (!m.in_reset) begin
            e.done = m.ended && (n >= m.done_e);
            e.core = (n >= m.rise) && !e.done;
            if (n < m.rise) e.cnt = 32'd0;
            else if (e.done) e.cnt = 32'(m.done_e - m.rise);
            else e.cnt = 32'(n - m.rise);
            e.st = m.st;
            e.mask = m.mask;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cnt(input bit sel_b, input logic [31:0] v);
        int k;
        k = 0;
        while (((sel_b ? count_b : count_a) !== v) && k < 3000) begin
            @(negedge tb_clk);
            k++;
        end
        chk(sel_b ? "wait_cnt_b" : "wait_cnt_a", sel_b ? count_b : count_a, v);
    endtask

    // Model advances on every clock edge and collapses on reset assertion.
    always @(posedge tb_clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl[0] = mdl_rst(mdl[0]);
            mdl[1] = mdl_rst(mdl[1]);
        end else begin
            edge_n++;
            mdl[0] = mdl_step(mdl[0], edge_n, trap_a, restart_a);
            mdl[1] = mdl_step(mdl[1], edge_n, trap_b, restart_b);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(posedge tb_clk) begin
        exp_t ea, eb;
        #1;
        if (chk_en) begin
            ea = mdl_exp(mdl[0], edge_n);
            eb = mdl_exp(mdl[1], edge_n);
            chk("a_core_rst_n", 32'(core_rst_n_a), 32'(ea.core));
            chk("a_done", 32'(done_a), 32'(ea.done));
            chk("a_status", 32'(status_a), 32'(ea.st));
            chk("a_mask", 32'(mask_a), 32'(ea.mask));
            chk("a_count", count_a, ea.cnt);
            chk("b_core_rst_n", 32'(core_rst_n_b), 32'(eb.core));
            chk("b_done", 32'(done_b), 32'(eb.done));
            chk("b_status", 32'(status_b), 32'(eb.st));
            chk("b_mask", 32'(mask_b), 32'(eb.mask));
            chk("b_count", count_b, eb.cnt);
        end
    end

    initial begin
        rst_n = 1'b0;
        trap_a = 4'b0000;
        trap_b = 4'b0000;
        restart_a = 1'b0;
        restart_b = 1'b0;
        n_checks = 0;
        n_errors = 0;
        chk_en = 1'b0;
        edge_n = 0;
        mdl[0] = mdl_init(10, 10, 1000);
        mdl[1] = mdl_init(3, 0, 100);
        repeat (3) @(negedge tb_clk);
        chk_en = 1'b1;
        chk("rst_core_a", 32'(core_rst_n_a), 32'd0);
        chk("rst_done_a", 32'(done_a), 32'd0);
        chk("rst_status_a", 32'(status_a), 32'd0);
        chk("rst_count_a", count_a, 32'd0);

        // Release: core reset rises on the 10th edge seen with rst_n high.
        rst_n = 1'b1;
        repeat (9) @(negedge tb_clk);
        chk("hold_edge9_core_a", 32'(core_rst_n_a), 32'd0);
        @(negedge tb_clk);
        chk("hold_edge10_core_a", 32'(core_rst_n_a), 32'd1);
        chk("hold_edge10_count_a", count_a, 32'd0);
        @(negedge tb_clk);
        chk("first_count_a", count_a, 32'd1);

        // Restart while running is ignored.
        wait_cnt(1'b0, 32'd20);
        restart_a = 1'b1;
        @(negedge tb_clk);
        restart_a = 1'b0;
        chk("run_restart_count_a", count_a, 32'd21);
        chk("run_restart_core_a", 32'(core_rst_n_a), 32'd1);

        // Hart 2 trap, then hart 1 during drain.
        wait_cnt(1'b0, 32'd49);
        trap_a = 4'b0100;
        @(negedge tb_clk);
        chk("trap_status_a", 32'(status_a), 32'd1);
        chk("trap_mask_a", 32'(mask_a), 32'h4);
        trap_a = 4'b0010;
        repeat (9) @(negedge tb_clk);
        chk("drain_done_a", 32'(done_a), 32'd0);
        chk("drain_count_a", count_a, 32'd59);
        @(negedge tb_clk);
        trap_a = 4'b0000;
        chk("done_a", 32'(done_a), 32'd1);
        chk("done_core_a", 32'(core_rst_n_a), 32'd0);
        chk("done_count_a", count_a, 32'd60);
        chk("done_mask_a", 32'(mask_a), 32'h4);
        repeat (5) @(negedge tb_clk);
        chk("frozen_count_a", count_a, 32'd60);

        // Restart from DONE.
        restart_a = 1'b1;
        @(negedge tb_clk);
        restart_a = 1'b0;
        chk("rs_done_a", 32'(done_a), 32'd0);
        chk("rs_status_a", 32'(status_a), 32'd0);
        chk("rs_mask_a", 32'(mask_a), 32'd0);
        chk("rs_count_a", count_a, 32'd0);
        chk("rs_core_a", 32'(core_rst_n_a), 32'd0);
        repeat (9) @(negedge tb_clk);
        chk("rs_edge9_core_a", 32'(core_rst_n_a), 32'd0);
        @(negedge tb_clk);
        chk("rs_edge10_core_a", 32'(core_rst_n_a), 32'd1);

        // Asynchronous reset in the middle of a drain.
        wait_cnt(1'b0, 32'd5);
        trap_a = 4'b0001;
        @(negedge tb_clk);
        trap_a = 4'b0000;
        repeat (3) @(negedge tb_clk);
        chk("pre_arst_status_a", 32'(status_a), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_status_a", 32'(status_a), 32'd0);
        chk("arst_mask_a", 32'(mask_a), 32'd0);
        chk("arst_count_a", count_a, 32'd0);
        chk("arst_core_a", 32'(core_rst_n_a), 32'd0);
        chk("arst_count_b", count_b, 32'd0);
        @(negedge tb_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge tb_clk);
        chk("rel_core_a", 32'(core_rst_n_a), 32'd1);

        // Zero-drain instance: end event goes straight to DONE.
        trap_b = 4'b1000;
        @(negedge tb_clk);
        trap_b = 4'b0000;
        chk("b_trap_done", 32'(done_b), 32'd1);
        chk("b_trap_core", 32'(core_rst_n_b), 32'd0);
        chk("b_trap_mask", 32'(mask_b), 32'h8);
        restart_b = 1'b1;
        @(negedge tb_clk);
        restart_b = 1'b0;
        chk("b_rs_done", 32'(done_b), 32'd0);
        chk("b_rs_count", count_b, 32'd0);
        repeat (2) @(negedge tb_clk);
        chk("b_rs_edge2_core", 32'(core_rst_n_b), 32'd0);
        @(negedge tb_clk);
        chk("b_rs_edge3_core", 32'(core_rst_n_b), 32'd1);
`ifdef SOC_RUN_CTRL_TIMEOUT_EN
        wait_cnt(1'b1, 32'd99);
        chk("b_pre_tmo_status", 32'(status_b), 32'd0);
        @(negedge tb_clk);
        chk("b_tmo_status", 32'(status_b), 32'd2);
        chk("b_tmo_done", 32'(done_b), 32'd1);
        chk("b_tmo_count", count_b, 32'd100);
        restart_b = 1'b1;
        @(negedge tb_clk);
        restart_b = 1'b0;
        wait_cnt(1'b1, 32'd99);
        trap_b = 4'b0001;
        @(negedge tb_clk);
        trap_b = 4'b0000;
        chk("b_tmo_trap_status", 32'(status_b), 32'd1);
        chk("b_tmo_trap_mask", 32'(mask_b), 32'h1);
        chk("b_tmo_trap_count", count_b, 32'd100);
`else
        wait_cnt(1'b1, 32'd150);
        chk("b_no_tmo_status", 32'(status_b), 32'd0);
        chk("b_no_tmo_done", 32'(done_b), 32'd0);
        trap_b = 4'b0110;
        @(negedge tb_clk);
        trap_b = 4'b0000;
        chk("b_late_status", 32'(status_b), 32'd1);
        chk("b_late_mask", 32'(mask_b), 32'h6);
        chk("b_late_count", count_b, 32'd151);
`endif
        repeat (3) @(negedge tb_clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
